// File: rtl/apb_uart_completer.sv
`default_nettype none
// ============================================================================
// Module   : apb_uart_completer
// Brief    : APB completer for the UART register window. Holds CTRL and the
//            one-byte TX/RX holding registers; stretches PREADY while busy.
// Revision : 1.0  initial release
// ============================================================================
module apb_uart_completer #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR,
  output logic [1:0]        ctrl_o,
  output logic              uart_run_flag_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [3:0]       A_CTRL  = 4'h0;
  localparam logic [3:0]       A_TX    = 4'h4;
  localparam logic [3:0]       A_RX    = 4'h8;
  localparam logic [3:0]       A_STAT  = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pready_q, pready_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        rx_hold_q, rx_hold_d;
  logic              rx_full_q, rx_full_d;
  logic              overrun_q, overrun_d;

  logic              addr_hi_bad;
  logic              is_ctrl, is_tx, is_rx, is_stat;
  logic              illegal, avail, commit, rx_pop, stat_rd;
  logic [DATA_W-1:0] rd_data;
  logic              unused_pwdata;

  generate
    if (ADDR_W > 4) begin : g_addr_hi
      assign addr_hi_bad = |PADDR[ADDR_W-1:4];
    end else begin : g_addr_no_hi
      assign addr_hi_bad = 1'b0;
    end
    if (DATA_W > 8) begin : g_wdata_hi
      assign unused_pwdata = ^PWDATA[DATA_W-1:8];
    end else begin : g_wdata_no_hi
      assign unused_pwdata = 1'b0;
    end
  endgenerate

  assign is_ctrl = (PADDR[3:0] == A_CTRL);
  assign is_tx   = (PADDR[3:0] == A_TX);
  assign is_rx   = (PADDR[3:0] == A_RX);
  assign is_stat = (PADDR[3:0] == A_STAT);

  assign illegal = addr_hi_bad
                 | (PADDR[1:0] != 2'b00)
                 | ( PWRITE & (is_rx | is_stat))
                 | (~PWRITE & is_tx)
                 | ( PWRITE & is_tx & ~ctrl_q[0])
                 | (~PWRITE & is_rx & ~ctrl_q[1]);

  assign avail = is_tx ? ~tx_valid_q : (is_rx ? rx_full_q : 1'b1);

  always_comb begin
    rd_data = '0;
    if (is_ctrl) begin
      rd_data[1:0] = ctrl_q;
    end else if (is_rx) begin
      rd_data[7:0] = rx_hold_q;
    end else if (is_stat) begin
      rd_data[4:0] = {ctrl_q, overrun_q, rx_full_q, tx_valid_q};
    end
  end

  // Transfer sequencing; response outputs are prepared one edge ahead.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    commit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (PSEL && PENABLE) begin
          if (illegal) begin
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else if (avail) begin
            state_d  = S_RESP;
            pready_d = 1'b1;
            commit   = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!illegal && avail) begin
          state_d  = S_RESP;
          pready_d = 1'b1;
          commit   = 1'b1;
          cnt_d    = '0;
        end else if (illegal || (cnt_q == CNT_MAX)) begin
          state_d   = S_RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (commit && !PWRITE) begin
      prdata_d = rd_data;
    end
  end

  assign rx_pop  = commit & ~PWRITE & is_rx;
  assign stat_rd = commit & ~PWRITE & is_stat;

  always_comb begin
    ctrl_d     = ctrl_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rx_hold_d  = rx_hold_q;
    rx_full_d  = rx_full_q;
    overrun_d  = overrun_q;
    if (commit && PWRITE && is_ctrl) begin
      ctrl_d = PWDATA[1:0];
    end
    if (tx_valid_q && tx_ready_i) begin
      tx_valid_d = 1'b0;
    end
    if (commit && PWRITE && is_tx) begin
      tx_data_d  = PWDATA[7:0];
      tx_valid_d = 1'b1;
    end
    if (rx_pop) begin
      rx_full_d = 1'b0;
    end
    if (stat_rd) begin
      overrun_d = 1'b0;
    end
    // A byte arriving during a pop refills the slot instead of overrunning.
    if (rx_valid_i) begin
      if (!rx_full_q || rx_pop) begin
        rx_hold_d = rx_data_i;
        rx_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      ctrl_q     <= 2'b00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      rx_hold_q  <= 8'h00;
      rx_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      ctrl_q     <= ctrl_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_hold_q  <= rx_hold_d;
      rx_full_q  <= rx_full_d;
      overrun_q  <= overrun_d;
    end
  end

  assign PREADY          = pready_q;
  assign PRDATA          = prdata_q;
  assign PSLVERR         = pslverr_q;
  assign ctrl_o          = ctrl_q;
  assign uart_run_flag_o = |ctrl_q;
  assign tx_data_o       = tx_data_q;
  assign tx_valid_o      = tx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_completer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_uart_completer
// Brief    : Directed and randomized APB traffic against a transaction-level
//            model of the UART register window.
// Revision : 1.0  initial release
// ============================================================================
module tb_apb_uart_completer;

  localparam int TIMEOUT = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [3:0]  PADDR = 4'h0;
  logic [31:0] PWDATA = 32'h0;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;
  logic [1:0]  ctrl_o;
  logic        uart_run_flag_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_uart_completer #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR), .ctrl_o(ctrl_o),
    .uart_run_flag_o(uart_run_flag_o), .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Register-window model, updated once per transaction or idle cycle.
  logic [1:0] m_ctrl;
  logic       m_txv, m_rxf, m_ovr;
  logic [7:0] m_txd, m_rxh;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic m_reset();
    m_ctrl = 2'b00; m_txv = 1'b0; m_txd = 8'h00;
    m_rxf = 1'b0; m_rxh = 8'h00; m_ovr = 1'b0;
  endtask

  task automatic m_rx(input logic [7:0] d);
    if (m_rxf) m_ovr = 1'b1;
    else begin
      m_rxh = d;
      m_rxf = 1'b1;
    end
  endtask

  function automatic bit m_illegal(input logic wr, input logic [3:0] a);
    return (a[1:0] != 2'b00) || (wr && (a == 4'h8 || a == 4'hC)) || (!wr && a == 4'h4)
        || (wr && a == 4'h4 && !m_ctrl[0]) || (!wr && a == 4'h8 && !m_ctrl[1]);
  endfunction

  function automatic bit m_avail(input logic [3:0] a);
    if (a == 4'h4) return !m_txv;
    if (a == 4'h8) return m_rxf;
    return 1'b1;
  endfunction

  task automatic m_commit(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                          output logic [31:0] rd);
    rd = 32'h0;
    case (a)
      4'h0: if (wr) m_ctrl = wd[1:0]; else rd = {30'd0, m_ctrl};
      4'h4: begin m_txd = wd[7:0]; m_txv = 1'b1; end
      4'h8: begin rd = {24'd0, m_rxh}; m_rxf = 1'b0; end
      default: begin rd = {27'd0, m_ctrl, m_ovr, m_rxf, m_txv}; m_ovr = 1'b0; end
    endcase
  endtask

  task automatic check_state();
    check_val("ctrl_o", {30'd0, ctrl_o}, {30'd0, m_ctrl});
    check_val("run_flag", {31'd0, uart_run_flag_o}, {31'd0, |m_ctrl});
    check_val("tx_valid", {31'd0, tx_valid_o}, {31'd0, m_txv});
    check_val("tx_data", {24'd0, tx_data_o}, {24'd0, m_txd});
    check_val("pready_low", {31'd0, PREADY}, 32'd0);
  endtask

  task automatic idle_cycle(input bit rxp, input logic [7:0] d, input bit txr);
    rx_valid_i = rxp; rx_data_i = d; tx_ready_i = txr;
    if (txr) m_txv = 1'b0;
    if (rxp) m_rx(d);
    tick();
    rx_valid_i = 1'b0; tx_ready_i = 1'b0;
  endtask

  // ek: 0 none, 1 rx_valid_i pulse, 2 tx_ready_i pulse, in access cycle ec (from 1).
  task automatic apb_xfer(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                          input int ek, input int ec, input logic [7:0] ed,
                          output logic [31:0] rd, output logic err, output int waits);
    bit done;
    rd = 32'h0; err = 1'b0; waits = 0; done = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
    tick();
    PENABLE = 1'b1;
    for (int n = 1; n <= 100 && !done; n++) begin
      if (ek == 1 && n == ec) begin rx_valid_i = 1'b1; rx_data_i = ed; end
      if (ek == 2 && n == ec) tx_ready_i = 1'b1;
      if (PREADY) begin
        done = 1'b1; rd = PRDATA; err = PSLVERR;
      end else begin
        waits++;
      end
      tick();
      rx_valid_i = 1'b0; tx_ready_i = 1'b0;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    if (!done) check_val("pready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_xfer(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                         input int ek, input int ec_in, input logic [7:0] ed,
                         output logic [31:0] rd, output logic err, output int waits);
    logic [31:0] e_rd;
    logic        e_err;
    int          e_w, ec;
    bit          ill, waiting, pre_txv;
    e_rd = 32'h0; e_err = 1'b0; e_w = 1;
    ill     = m_illegal(wr, a);
    waiting = !ill && !m_avail(a);
    ec      = waiting ? ec_in : 1;
    pre_txv = m_txv;
    if (ill) begin
      if (ek == 2) m_txv = 1'b0;
      if (ek == 1) m_rx(ed);
      e_err = 1'b1;
    end else if (!waiting) begin
      m_commit(wr, a, wd, e_rd);
      if (ek == 2 && pre_txv) m_txv = 1'b0;
      if (ek == 1) m_rx(ed);
    end else begin
      if (ek == 2) m_txv = 1'b0;
      if (ek == 1) m_rx(ed);
      if (ek != 0 && m_avail(a)) begin
        e_w = ec + 1;
        m_commit(wr, a, wd, e_rd);
      end else begin
        e_w = TIMEOUT + 1;
        e_err = 1'b1;
      end
    end
    apb_xfer(wr, a, wd, ek, ec, ed, rd, err, waits);
    check_val("prdata", rd, e_rd);
    check_val("pslverr", {31'd0, err}, {31'd0, e_err});
    check_val("waits", 32'(waits), 32'(e_w));
    check_state();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, wd;
    logic        err, wr;
    logic [3:0]  a;
    int          waits, r, gap, ek, ec;

    // Reset then idle
    PRESETn = 1'b0;
    tick(); tick();
    PRESETn = 1'b1;
    m_reset();
    check_val("rst_pready", {31'd0, PREADY}, 32'd0);
    check_val("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    check_val("rst_prdata", PRDATA, 32'd0);
    check_state();
    do_xfer(1'b0, 4'hC, 32'h0, 0, 1, 8'h00, rd, err, waits);
    check_val("rst_status", rd, 32'h0);
    check_val("rst_status_waits", 32'(waits), 32'd1);

    // CTRL and TX path including a stretched TXDATA write
    do_xfer(1'b1, 4'h0, 32'h3, 0, 1, 8'h00, rd, err, waits);
    do_xfer(1'b1, 4'h4, 32'hFFFF_FFA5, 0, 1, 8'h00, rd, err, waits);
    check_val("tx_a5", {24'd0, tx_data_o}, 32'hA5);
    check_val("run_on", {31'd0, uart_run_flag_o}, 32'd1);
    do_xfer(1'b1, 4'h4, 32'h5A, 2, 3, 8'h00, rd, err, waits);
    check_val("tx_5a_waits", 32'(waits), 32'd4);
    check_val("tx_5a_err", {31'd0, err}, 32'd0);
    check_val("tx_5a_data", {24'd0, tx_data_o}, 32'h5A);
    idle_cycle(1'b0, 8'h00, 1'b1);

    // RX timeout, then a byte arriving mid-wait
    do_xfer(1'b0, 4'h8, 32'h0, 0, 1, 8'h00, rd, err, waits);
    check_val("rx_to_err", {31'd0, err}, 32'd1);
    check_val("rx_to_waits", 32'(waits), 32'(TIMEOUT + 1));
    do_xfer(1'b0, 4'h8, 32'h0, 1, 5, 8'h3C, rd, err, waits);
    check_val("rx_3c", rd, 32'h3C);
    do_xfer(1'b0, 4'hC, 32'h0, 0, 1, 8'h00, rd, err, waits);
    check_val("status_after_pop", rd, 32'h18);

    // Overrun stickiness and clear-on-read
    idle_cycle(1'b1, 8'h11, 1'b0);
    idle_cycle(1'b1, 8'h22, 1'b0);
    do_xfer(1'b0, 4'hC, 32'h0, 0, 1, 8'h00, rd, err, waits);
    check_val("status_ovr", rd, 32'h1E);
    do_xfer(1'b0, 4'hC, 32'h0, 0, 1, 8'h00, rd, err, waits);
    check_val("status_ovr_clr", rd, 32'h1A);
    do_xfer(1'b0, 4'h8, 32'h0, 0, 1, 8'h00, rd, err, waits);
    check_val("rx_11", rd, 32'h11);

    // Illegal accesses
    do_xfer(1'b1, 4'h8, 32'hFF, 0, 1, 8'h00, rd, err, waits);
    check_val("ill_wr_rx", {31'd0, err}, 32'd1);
    do_xfer(1'b0, 4'h4, 32'h0, 0, 1, 8'h00, rd, err, waits);
    check_val("ill_rd_tx", {31'd0, err}, 32'd1);
    do_xfer(1'b0, 4'h2, 32'h0, 0, 1, 8'h00, rd, err, waits);
    check_val("ill_addr2", {31'd0, err}, 32'd1);
    check_val("ill_addr2_waits", 32'(waits), 32'd1);
    do_xfer(1'b1, 4'h0, 32'h2, 0, 1, 8'h00, rd, err, waits);
    do_xfer(1'b1, 4'h4, 32'h33, 0, 1, 8'h00, rd, err, waits);
    check_val("ill_tx_dis", {31'd0, err}, 32'd1);
    check_val("ill_tx_dis_valid", {31'd0, tx_valid_o}, 32'd0);
    do_xfer(1'b1, 4'h0, 32'h3, 0, 1, 8'h00, rd, err, waits);

    // Same-edge RX pop/refill and overrun set-over-clear
    idle_cycle(1'b1, 8'h44, 1'b0);
    do_xfer(1'b0, 4'h8, 32'h0, 1, 1, 8'h55, rd, err, waits);
    check_val("pop_refill", rd, 32'h44);
    do_xfer(1'b0, 4'hC, 32'h0, 0, 1, 8'h00, rd, err, waits);
    check_val("refill_no_ovr", rd, 32'h1A);
    idle_cycle(1'b1, 8'h66, 1'b0);
    do_xfer(1'b0, 4'hC, 32'h0, 1, 1, 8'h77, rd, err, waits);
    check_val("ovr_set_wins_a", rd, 32'h1E);
    do_xfer(1'b0, 4'hC, 32'h0, 0, 1, 8'h00, rd, err, waits);
    check_val("ovr_set_wins_b", rd, 32'h1E);
    do_xfer(1'b0, 4'h8, 32'h0, 0, 1, 8'h00, rd, err, waits);
    check_val("rx_55", rd, 32'h55);

    // Reset in the middle of a stretched TXDATA write
    do_xfer(1'b1, 4'h4, 32'h77, 0, 1, 8'h00, rd, err, waits);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h4; PWDATA = 32'h99;
    tick();
    PENABLE = 1'b1;
    tick(); tick(); tick();
    check_val("wait_pready", {31'd0, PREADY}, 32'd0);
    PRESETn = 1'b0;
    tick();
    PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    m_reset();
    check_val("wrst_pready", {31'd0, PREADY}, 32'd0);
    check_state();
    do_xfer(1'b0, 4'hC, 32'h0, 0, 1, 8'h00, rd, err, waits);
    check_val("wrst_status", rd, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
        idle_cycle($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    a = 4'h0;
        2, 3:    a = 4'h4;
        4, 5:    a = 4'h8;
        6, 7:    a = 4'hC;
        default: a = 4'($urandom);
      endcase
      wr = 1'($urandom);
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) wd[1:0] = 2'b11;
      ek = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2)) : 0;
      ec = $urandom_range(1, TIMEOUT);
      do_xfer(wr, a, wd, ek, ec, 8'($urandom), rd, err, waits);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
